// File: rtl/controladora_multicanal_if.sv
// Per-channel button/presence inputs and lamp/mode-LED outputs of the
// multichannel lighting controller, bundled with master/slave views.
interface controladora_multicanal_if #(
    parameter int unsigned N_CH = 4
);
    logic [N_CH-1:0] push_button;
    logic [N_CH-1:0] infra;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] saida;

    modport master (output push_button, output infra, input led, input saida);
    modport slave  (input push_button, input infra, output led, output saida);
endinterface

// File: rtl/controladora_multicanal.sv
// N-channel lighting controller: debounced button, presence sensor, manual/auto
// modes with hold timer. Pre-shutdown warning blink enabled by CONTROLADORA_WARN_EN.
module controladora_multicanal #(
    parameter int unsigned N_CH              = 4,
    parameter int unsigned TICK_DIV          = 50000,
    parameter int unsigned DEBOUNCE_P        = 300,
    parameter int unsigned SWITCH_MODE_MIN_T = 5000,
    parameter int unsigned AUTO_SHUTDOWN_T   = 30000,
    parameter int unsigned WARN_T            = 5000,
    parameter int unsigned BLINK_HALF        = 250
) (
    input  logic                     clk,
    input  logic                     rst,
    controladora_multicanal_if.slave io
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam int unsigned DW = $clog2(DEBOUNCE_P + 1);
    localparam int unsigned SW = $clog2(SWITCH_MODE_MIN_T + 1);
    localparam int unsigned TW = $clog2(AUTO_SHUTDOWN_T + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_P - 1);
    localparam logic [SW-1:0] LONG_T     = SW'(SWITCH_MODE_MIN_T);
    localparam logic [TW-1:0] SHUT_T     = TW'(AUTO_SHUTDOWN_T);

    if (N_CH < 1 || TICK_DIV < 2 || DEBOUNCE_P < 1 || SWITCH_MODE_MIN_T < 1 ||
        WARN_T >= AUTO_SHUTDOWN_T || BLINK_HALF < 1) begin : g_param_check
        $error("controladora_multicanal: invalid parameter set");
    end

`ifdef CONTROLADORA_WARN_EN
    localparam int unsigned   BW         = $clog2(BLINK_HALF + 1);
    localparam logic [TW-1:0] WARN_AT    = TW'(AUTO_SHUTDOWN_T - WARN_T);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic [2:0] {MAN_OFF, MAN_ON, AUTO_IDLE, AUTO_ON, AUTO_WARN} state_t;

    logic [BW-1:0]   blink_cnt_q [N_CH];
    logic [BW-1:0]   blink_cnt_d [N_CH];
    logic [N_CH-1:0] blink_lvl_q, blink_lvl_d;
`else
    typedef enum logic [2:0] {MAN_OFF, MAN_ON, AUTO_IDLE, AUTO_ON} state_t;
`endif

    logic [PW-1:0]   presc_q, presc_d;
    logic            tick;
    logic [N_CH-1:0] pb_meta_q, pb_meta_d, pb_sync_q, pb_sync_d;
    logic [N_CH-1:0] ir_meta_q, ir_meta_d, ir_sync_q, ir_sync_d;
    logic [N_CH-1:0] clean_q, clean_d, clean_prev_q, clean_prev_d;
    logic [N_CH-1:0] press_fall, long_press, short_press;
    logic [N_CH-1:0] led_q, led_d, saida_q, saida_d;
    logic [DW-1:0]   deb_q   [N_CH];
    logic [DW-1:0]   deb_d   [N_CH];
    logic [SW-1:0]   press_q [N_CH];
    logic [SW-1:0]   press_d [N_CH];
    logic [TW-1:0]   timer_q [N_CH];
    logic [TW-1:0]   timer_d [N_CH];
    state_t          state_q [N_CH];
    state_t          state_d [N_CH];

    always_comb begin
        tick         = (presc_q == PRESC_LAST);
        presc_d      = tick ? '0 : presc_q + 1'b1;
        pb_meta_d    = io.push_button;
        pb_sync_d    = pb_meta_q;
        ir_meta_d    = io.infra;
        ir_sync_d    = ir_meta_q;
        clean_d      = clean_q;
        clean_prev_d = clean_q;
        press_fall   = clean_prev_q & ~clean_q;
        long_press   = '0;
        short_press  = '0;
        led_d        = '0;
        saida_d      = '0;
`ifdef CONTROLADORA_WARN_EN
        blink_lvl_d  = blink_lvl_q;
`endif
        for (int unsigned c = 0; c < N_CH; c++) begin
            deb_d[c]   = deb_q[c];
            press_d[c] = press_q[c];
            timer_d[c] = timer_q[c];
            state_d[c] = state_q[c];
`ifdef CONTROLADORA_WARN_EN
            blink_cnt_d[c] = blink_cnt_q[c];
`endif
            if (pb_sync_q[c] == clean_q[c]) begin
                deb_d[c] = '0;
            end else if (tick) begin
                if (deb_q[c] == DEB_LAST) begin
                    clean_d[c] = pb_sync_q[c];
                    deb_d[c]   = '0;
                end else begin
                    deb_d[c] = deb_q[c] + 1'b1;
                end
            end

            // Press length is judged one clk after pb_clean falls, then cleared.
            long_press[c]  = press_fall[c] && (press_q[c] == LONG_T);
            short_press[c] = press_fall[c] && (press_q[c] != LONG_T);
            if (press_fall[c]) begin
                press_d[c] = '0;
            end else if (clean_q[c] && tick && (press_q[c] != LONG_T)) begin
                press_d[c] = press_q[c] + 1'b1;
            end

            if (long_press[c]) begin
                timer_d[c] = '0;
                if (state_q[c] == MAN_OFF || state_q[c] == MAN_ON) state_d[c] = AUTO_IDLE;
                else                                               state_d[c] = MAN_OFF;
            end else begin
                case (state_q[c])
                    MAN_OFF: if (short_press[c]) state_d[c] = MAN_ON;
                    MAN_ON:  if (short_press[c]) state_d[c] = MAN_OFF;
                    AUTO_IDLE: begin
                        if (ir_sync_q[c]) begin
                            state_d[c] = AUTO_ON;
                            timer_d[c] = '0;
                        end
                    end
                    AUTO_ON: begin
                        if (ir_sync_q[c]) begin
                            timer_d[c] = '0;
                        end else if (tick) begin
                            timer_d[c] = timer_q[c] + 1'b1;
`ifdef CONTROLADORA_WARN_EN
                            if (timer_d[c] == WARN_AT) begin
                                state_d[c]     = AUTO_WARN;
                                blink_cnt_d[c] = '0;
                                blink_lvl_d[c] = 1'b0;
                            end
`else
                            if (timer_d[c] == SHUT_T) state_d[c] = AUTO_IDLE;
`endif
                        end
                    end
`ifdef CONTROLADORA_WARN_EN
                    AUTO_WARN: begin
                        if (ir_sync_q[c]) begin
                            state_d[c] = AUTO_ON;
                            timer_d[c] = '0;
                        end else if (tick) begin
                            timer_d[c] = timer_q[c] + 1'b1;
                            if (timer_d[c] == SHUT_T) state_d[c] = AUTO_IDLE;
                            if (blink_cnt_q[c] == BLINK_LAST) begin
                                blink_cnt_d[c] = '0;
                                blink_lvl_d[c] = ~blink_lvl_q[c];
                            end else begin
                                blink_cnt_d[c] = blink_cnt_q[c] + 1'b1;
                            end
                        end
                    end
`endif
                    default: state_d[c] = AUTO_IDLE;
                endcase
            end

            // Outputs decoded from the next state so they register with it.
            led_d[c]   = (state_d[c] == MAN_OFF) || (state_d[c] == MAN_ON);
            saida_d[c] = (state_d[c] == MAN_ON) || (state_d[c] == AUTO_ON);
`ifdef CONTROLADORA_WARN_EN
            if (state_d[c] == AUTO_WARN) saida_d[c] = blink_lvl_d[c];
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q      <= '0;
            pb_meta_q    <= '0;
            pb_sync_q    <= '0;
            ir_meta_q    <= '0;
            ir_sync_q    <= '0;
            clean_q      <= '0;
            clean_prev_q <= '0;
            led_q        <= '0;
            saida_q      <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                deb_q[c]   <= '0;
                press_q[c] <= '0;
                timer_q[c] <= '0;
                state_q[c] <= AUTO_IDLE;
`ifdef CONTROLADORA_WARN_EN
                blink_cnt_q[c] <= '0;
`endif
            end
`ifdef CONTROLADORA_WARN_EN
            blink_lvl_q  <= '0;
`endif
        end else begin
            presc_q      <= presc_d;
            pb_meta_q    <= pb_meta_d;
            pb_sync_q    <= pb_sync_d;
            ir_meta_q    <= ir_meta_d;
            ir_sync_q    <= ir_sync_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_prev_d;
            led_q        <= led_d;
            saida_q      <= saida_d;
            deb_q        <= deb_d;
            press_q      <= press_d;
            timer_q      <= timer_d;
            state_q      <= state_d;
`ifdef CONTROLADORA_WARN_EN
            blink_cnt_q  <= blink_cnt_d;
            blink_lvl_q  <= blink_lvl_d;
`endif
        end
    end

    assign io.led   = led_q;
    assign io.saida = saida_q;

endmodule

// File: tb/tb_controladora_multicanal.sv
// Directed bench for controladora_multicanal: table of button vectors plus
// hand sequences for presence latency, hold timer/blink and async reset.
module tb_controladora_multicanal;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned SHUT     = 20;
    localparam int unsigned WARN     = 8;
    localparam int unsigned HALF     = 2;
    localparam int unsigned NVEC     = 22;

    typedef struct {
        logic [1:0]  pb;
        logic [1:0]  ir;
        int unsigned clks;
        logic [1:0]  led;
        logic [1:0]  saida;
    } vec_t;

    logic        clk;
    logic        rst;
    int unsigned checks;
    int unsigned errors;
    int unsigned edge_cnt;
    vec_t        tbl [NVEC];

    controladora_multicanal_if #(.N_CH(2)) io ();

    controladora_multicanal #(
        .N_CH(2),
        .TICK_DIV(TICK_DIV),
        .DEBOUNCE_P(3),
        .SWITCH_MODE_MIN_T(10),
        .AUTO_SHUTDOWN_T(SHUT),
        .WARN_T(WARN),
        .BLINK_HALF(HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io(io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) edge_cnt <= 0;
        else     edge_cnt <= edge_cnt + 1;
    end

    task automatic check(input string name, input logic [1:0] got, input logic [1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Channel 0 lamp level after the n-th tick of an unoccupied hold window.
    function automatic logic exp_auto(input int unsigned n);
`ifdef CONTROLADORA_WARN_EN
        if (n < SHUT - WARN) return 1'b1;
        if (n >= SHUT)       return 1'b0;
        return (((n - (SHUT - WARN)) / HALF) % 2) == 1;
`else
        return n < SHUT;
`endif
    endfunction

    task automatic align_tick();
        for (int i = 0; i < 4 && (edge_cnt % TICK_DIV) != 0; i++) @(negedge clk);
    endtask

    task automatic presence_pulse(input logic [1:0] ch);
        io.infra = ch;
        @(negedge clk);
        io.infra = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        checks = 0;
        errors = 0;
        tbl[0]  = '{2'b10, 2'b00, 48, 2'b00, 2'b00};  // ch1 long press held
        tbl[1]  = '{2'b00, 2'b00, 16, 2'b10, 2'b00};  // -> MAN_OFF
        tbl[2]  = '{2'b10, 2'b00, 20, 2'b10, 2'b00};
        tbl[3]  = '{2'b00, 2'b00, 16, 2'b10, 2'b10};  // short -> MAN_ON
        tbl[4]  = '{2'b10, 2'b00, 20, 2'b10, 2'b10};
        tbl[5]  = '{2'b00, 2'b00, 16, 2'b10, 2'b00};  // short -> MAN_OFF
        tbl[6]  = '{2'b10, 2'b00,  8, 2'b10, 2'b00};  // 2-tick glitch
        tbl[7]  = '{2'b00, 2'b00, 16, 2'b10, 2'b00};
        tbl[8]  = '{2'b10, 2'b00,  3, 2'b10, 2'b00};  // bounce 1,0,1
        tbl[9]  = '{2'b00, 2'b00,  2, 2'b10, 2'b00};
        tbl[10] = '{2'b10, 2'b00,  3, 2'b10, 2'b00};
        tbl[11] = '{2'b00, 2'b00, 16, 2'b10, 2'b00};
        tbl[12] = '{2'b10, 2'b00, 36, 2'b10, 2'b00};  // 9 ticks: short
        tbl[13] = '{2'b00, 2'b00, 16, 2'b10, 2'b10};
        tbl[14] = '{2'b10, 2'b00, 40, 2'b10, 2'b10};  // exactly 10 ticks: long
        tbl[15] = '{2'b00, 2'b00, 16, 2'b00, 2'b00};  // -> AUTO_IDLE
        tbl[16] = '{2'b10, 2'b00, 48, 2'b00, 2'b00};
        tbl[17] = '{2'b00, 2'b00, 16, 2'b10, 2'b00};  // -> MAN_OFF
        tbl[18] = '{2'b10, 2'b00, 20, 2'b10, 2'b00};
        tbl[19] = '{2'b00, 2'b00, 16, 2'b10, 2'b10};  // -> MAN_ON
        tbl[20] = '{2'b01, 2'b00, 20, 2'b10, 2'b10};  // ch0 short press in auto
        tbl[21] = '{2'b00, 2'b00, 16, 2'b10, 2'b10};  // ignored

        rst            = 1'b1;
        io.push_button = 2'b00;
        io.infra       = 2'b00;
        repeat (2) @(negedge clk);
        check("reset_led", io.led, 2'b00);
        check("reset_saida", io.saida, 2'b00);

        // Released on a negedge, so the first tick lands on the 4th edge.
        rst      = 1'b0;
        io.infra = 2'b01;
        @(negedge clk);
        check("ir_edge1", io.saida, 2'b00);
        io.infra = 2'b00;
        @(negedge clk);
        check("ir_edge2", io.saida, 2'b00);
        @(negedge clk);
        check("ir_edge3_saida", io.saida, 2'b01);
        check("ir_edge3_led", io.led, 2'b00);

        for (int unsigned n = 1; n <= SHUT + 2; n++) begin
            repeat ((n == 1) ? 1 : TICK_DIV) @(negedge clk);
            check($sformatf("hold_tick%0d", n), io.saida, {1'b0, exp_auto(n)});
        end

        for (int i = 0; i < NVEC; i++) begin
            io.push_button = tbl[i].pb;
            io.infra       = tbl[i].ir;
            repeat (tbl[i].clks) @(negedge clk);
            check($sformatf("vec%0d_led", i), io.led, tbl[i].led);
            check($sformatf("vec%0d_saida", i), io.saida, tbl[i].saida);
        end

        align_tick();
        presence_pulse(2'b01);
        check("retrig_on", io.saida, 2'b11);
        repeat (49) @(negedge clk);
        check("retrig_tick13", io.saida, {1'b1, exp_auto(13)});
        presence_pulse(2'b01);
        check("presence_restore", io.saida, 2'b11);
        repeat (49) @(negedge clk);
        check("second_tick13", io.saida, {1'b1, exp_auto(13)});
        check("second_tick13_led", io.led, 2'b10);

        #2 rst = 1'b1;
        #1;
        check("async_rst_saida", io.saida, 2'b00);
        check("async_rst_led", io.led, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_led", io.led, 2'b00);
        presence_pulse(2'b10);
        check("post_rst_auto_saida", io.saida, 2'b10);
        check("post_rst_auto_led", io.led, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
